// File: rtl/xadc_drp_responder.sv
// DRP responder emulating the XADC register file: 16 aux sample registers plus 3 RW config registers.
// Latency: drdy_out pulses RD_LATENCY cycles after an accepted den_in; eoc_out pulses 1 cycle after smp_valid.
// Backpressure: none; den_in while busy is dropped and flagged in sticky den_overrun, smp_valid accepted every cycle.
module xadc_drp_responder #(
    parameter int          RD_LATENCY = 4,        // legal range 1..15
    parameter logic [15:0] CFG0_RST   = 16'h0000,
    parameter logic [15:0] CFG1_RST   = 16'h0000,
    parameter logic [15:0] CFG2_RST   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [6:0]  daddr_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    input  logic        smp_valid,
    input  logic [3:0]  smp_ch,
    input  logic [11:0] smp_data,
    output logic        eoc_out,
    output logic [4:0]  channel_out,
    output logic        den_overrun
);

    localparam logic [3:0] CNT_INIT = 4'(RD_LATENCY - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_nxt_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_nxt_cnt;
    logic        w_accept;
    logic        w_drdy;
    logic        w_busy_hit;

    logic [11:0] r_smp [16];
    logic [15:0] r_cfg [3];
    logic [15:0] r_resp;
    logic [15:0] r_do_hold;
    logic        r_eoc;
    logic [4:0]  r_channel;
    logic        r_overrun;

    logic        w_is_aux;
    logic        w_is_cfg;
    logic [15:0] w_rd_word;

    // Address decode: every address bit is compared, so 0x20..0x3F etc. never alias onto aux/cfg.
    always_comb begin
        w_is_aux  = (daddr_in[6:4] == 3'b001);
        w_is_cfg  = (daddr_in[6:2] == 5'b10000) && (daddr_in[1:0] != 2'b11);
        w_rd_word = 16'h0000;
        if (w_is_aux) begin
            w_rd_word = {r_smp[daddr_in[3:0]], 4'b0000};
        end else if (w_is_cfg) begin
            case (daddr_in[1:0])
                2'b00:   w_rd_word = r_cfg[0];
                2'b01:   w_rd_word = r_cfg[1];
                default: w_rd_word = r_cfg[2];
            endcase
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, acknowledge when the count reaches zero.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_accept    = 1'b0;
        w_drdy      = 1'b0;
        w_busy_hit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (den_in) begin
                    w_accept    = 1'b1;
                    w_nxt_state = S_BUSY;
                    w_nxt_cnt   = CNT_INIT;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0) begin
                    // den_in during the ack cycle is dropped silently.
                    w_drdy      = 1'b1;
                    w_nxt_state = S_IDLE;
                end else begin
                    w_nxt_cnt  = r_cnt - 4'd1;
                    w_busy_hit = den_in;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = 4'd0;
            end
        endcase
    end

    // State and latency counter registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    // Response word is frozen at accept; the visible read data only moves on the ack cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp    <= 16'h0000;
            r_do_hold <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_resp <= dwe_in ? 16'h0000 : w_rd_word;
            end
            if (w_drdy) begin
                r_do_hold <= r_resp;
            end
        end
    end

    // Config register writes happen in the accept cycle; other write targets are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg[0] <= CFG0_RST;
            r_cfg[1] <= CFG1_RST;
            r_cfg[2] <= CFG2_RST;
        end else if (w_accept && dwe_in && w_is_cfg) begin
            r_cfg[daddr_in[1:0]] <= di_in;
        end
    end

    // Sample capture from the front end; a same-cycle read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_smp[i] <= 12'h000;
            end
        end else if (smp_valid) begin
            r_smp[smp_ch] <= smp_data;
        end
    end

    // End-of-conversion pulse and channel code follow each sample write by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eoc     <= 1'b0;
            r_channel <= 5'h00;
        end else begin
            r_eoc <= smp_valid;
            if (smp_valid) begin
                r_channel <= {1'b1, smp_ch};
            end
        end
    end

    // Sticky overrun flag for requests arriving while a transaction is still counting down.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_busy_hit) begin
            r_overrun <= 1'b1;
        end
    end

    assign drdy_out    = w_drdy;
    assign do_out      = w_drdy ? r_resp : r_do_hold;
    assign eoc_out     = r_eoc;
    assign channel_out = r_channel;
    assign den_overrun = r_overrun;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Randomized + directed bench for xadc_drp_responder with a scoreboard and reference model.
// Stimulus pushes expected responses by cycle; a negedge monitor pops and compares.
// Model works from transaction rules (accept windows, address map), not the RTL structure.
module tb_xadc_drp_responder;

    localparam int RD_LAT = 4;

    logic        clk;
    logic        rst;
    logic        den_in;
    logic        dwe_in;
    logic [6:0]  daddr_in;
    logic [15:0] di_in;
    logic [15:0] do_out;
    logic        drdy_out;
    logic        smp_valid;
    logic [3:0]  smp_ch;
    logic [11:0] smp_data;
    logic        eoc_out;
    logic [4:0]  channel_out;
    logic        den_overrun;

    xadc_drp_responder #(
        .RD_LATENCY (RD_LAT),
        .CFG0_RST   (16'hA5A5),
        .CFG1_RST   (16'h0F0F),
        .CFG2_RST   (16'h8001)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .den_in      (den_in),
        .dwe_in      (dwe_in),
        .daddr_in    (daddr_in),
        .di_in       (di_in),
        .do_out      (do_out),
        .drdy_out    (drdy_out),
        .smp_valid   (smp_valid),
        .smp_ch      (smp_ch),
        .smp_data    (smp_data),
        .eoc_out     (eoc_out),
        .channel_out (channel_out),
        .den_overrun (den_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Reference model state
    logic [11:0] m_smp [16];
    logic [15:0] m_cfg [3];
    int          m_next_free;
    int          m_ovr_from;
    logic [15:0] m_last_do;
    logic [4:0]  m_chan;

    int          q_rd_cyc [$];
    logic [15:0] q_rd_dat [$];
    int          q_eoc_cyc [$];
    logic [4:0]  q_eoc_ch [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [6:0] a);
        if (a >= 7'h10 && a <= 7'h1F) return {m_smp[a - 7'h10], 4'h0};
        if (a >= 7'h40 && a <= 7'h42) return m_cfg[a - 7'h40];
        return 16'h0000;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_smp[i] = 12'h000;
        m_cfg[0] = 16'hA5A5;
        m_cfg[1] = 16'h0F0F;
        m_cfg[2] = 16'h8001;
        q_rd_cyc.delete();
        q_rd_dat.delete();
        q_eoc_cyc.delete();
        q_eoc_ch.delete();
        m_next_free = cyc;
        m_ovr_from  = -1;
        m_last_do   = 16'h0000;
        m_chan      = 5'h00;
    endtask

    // Drive one cycle of inputs and advance the model by the transaction rules.
    task automatic step(input bit r, input bit d, input bit w, input logic [6:0] a,
                        input logic [15:0] x, input bit sv, input logic [3:0] ch,
                        input logic [11:0] sd);
        int c;
        rst = r; den_in = d; dwe_in = w; daddr_in = a; di_in = x;
        smp_valid = sv; smp_ch = ch; smp_data = sd;
        c = cyc;
        if (!r) begin
            if (d && c >= m_next_free) begin
                q_rd_cyc.push_back(c + RD_LAT);
                q_rd_dat.push_back(w ? 16'h0000 : m_read(a));
                if (w && a >= 7'h40 && a <= 7'h42) m_cfg[a - 7'h40] = x;
                m_next_free = c + RD_LAT + 1;
            end else if (d && c < m_next_free - 1) begin
                if (m_ovr_from < 0) m_ovr_from = c + 1;
            end
            if (sv) begin
                m_smp[ch] = sd;
                q_eoc_cyc.push_back(c + 1);
                q_eoc_ch.push_back({1'b1, ch});
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_reset();
            chk_en = 1;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 7'h00, 16'h0000, 0, 4'h0, 12'h000);
    endtask

    task automatic req(input bit w, input logic [6:0] a, input logic [15:0] x);
        while (cyc < m_next_free) idle();
        step(0, 1, w, a, x, 0, 4'h0, 12'h000);
    endtask

    task automatic smp(input logic [3:0] ch, input logic [11:0] sd);
        step(0, 0, 0, 7'h00, 16'h0000, 1, ch, sd);
    endtask

    // Monitor: compare every DUT output each cycle against the scoreboard.
    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_d;
            bit exp_e;
            exp_d = (q_rd_cyc.size() > 0) && (q_rd_cyc[0] == cyc);
            chk("drdy_out", {31'd0, drdy_out}, {31'd0, exp_d});
            if (exp_d) begin
                void'(q_rd_cyc.pop_front());
                m_last_do = q_rd_dat.pop_front();
            end
            chk("do_out", {16'd0, do_out}, {16'd0, m_last_do});
            exp_e = (q_eoc_cyc.size() > 0) && (q_eoc_cyc[0] == cyc);
            chk("eoc_out", {31'd0, eoc_out}, {31'd0, exp_e});
            if (exp_e) begin
                void'(q_eoc_cyc.pop_front());
                m_chan = q_eoc_ch.pop_front();
            end
            chk("channel_out", {27'd0, channel_out}, {27'd0, m_chan});
            chk("den_overrun", {31'd0, den_overrun},
                {31'd0, (m_ovr_from >= 0 && cyc >= m_ovr_from)});
        end
    end

    initial begin
        bit         tog;
        bit         acc;
        logic [6:0] a;
        int         sel;
        rst = 1; den_in = 0; dwe_in = 0; daddr_in = '0; di_in = '0;
        smp_valid = 0; smp_ch = '0; smp_data = '0;
        @(posedge clk);
        #1;

        // Reset, then reads of aux and config registers at reset values.
        step(1, 0, 0, 7'h00, 16'h0000, 0, 4'h0, 12'h000);
        step(1, 0, 0, 7'h00, 16'h0000, 0, 4'h0, 12'h000);
        idle();
        req(0, 7'h13, 16'hFFFF);
        req(0, 7'h40, 16'h0000);
        req(0, 7'h41, 16'h0000);
        req(0, 7'h42, 16'h0000);

        // Sample write then readback, eoc/channel tracking.
        while (cyc < m_next_free) idle();
        smp(4'h3, 12'hABC);
        req(0, 7'h13, 16'h0000);
        smp(4'hB, 12'h321);
        smp(4'h2, 12'h055);

        // den held high; alternate the address on each accepted request.
        while (cyc < m_next_free) idle();
        tog = 0;
        for (int i = 0; i < 20; i++) begin
            acc = (cyc >= m_next_free);
            step(0, 1, 0, tog ? 7'h1B : 7'h13, 16'h0000, 0, 4'h0, 12'h000);
            if (acc) tog = ~tog;
        end

        // Config write/readback, dropped writes to read-only and unmapped space.
        req(1, 7'h41, 16'h1234);
        req(0, 7'h41, 16'h0000);
        req(1, 7'h13, 16'hDEAD);
        req(0, 7'h13, 16'h0000);
        req(1, 7'h43, 16'hBEEF);
        req(0, 7'h43, 16'h0000);
        req(0, 7'h53, 16'h0000);
        req(0, 7'h33, 16'h0000);
        req(0, 7'h00, 16'h0000);
        req(0, 7'h7F, 16'h0000);

        // Same-cycle sample write and read of that channel returns the old value.
        while (cyc < m_next_free) idle();
        smp(4'hB, 12'h100);
        while (cyc < m_next_free) idle();
        step(0, 1, 0, 7'h1B, 16'h0000, 1, 4'hB, 12'h7FF);
        req(0, 7'h1B, 16'h0000);

        // Reset two cycles after an accept aborts the transaction.
        req(0, 7'h41, 16'h0000);
        idle();
        step(1, 0, 0, 7'h00, 16'h0000, 0, 4'h0, 12'h000);
        idle();
        req(0, 7'h41, 16'h0000);
        smp(4'h7, 12'hFED);
        req(0, 7'h17, 16'h0000);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       a = 7'h10 + 7'($urandom_range(0, 15));
                1:       a = 7'h40 + 7'($urandom_range(0, 3));
                2:       a = 7'h10 + 7'($urandom_range(0, 1) * 16);
                default: a = 7'($urandom);
            endcase
            step(0, ($urandom_range(0, 2) == 0), $urandom_range(0, 1), a, 16'($urandom),
                 ($urandom_range(0, 2) == 0), 4'($urandom), 12'($urandom));
        end

        for (int i = 0; i < 10; i++) idle();
        chk("rd_queue_drained", q_rd_cyc.size(), 0);
        chk("eoc_queue_drained", q_eoc_cyc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
